// File: rtl/main_mem_pkg.sv
// rtl/main_mem_pkg.sv - shared FSM state type and address-split helpers for the main memory responder
package main_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        RESP  = 2'd2,
        DRAIN = 2'd3
    } mm_state_t;

    function automatic int off_bits(input int line_bits);
        return $clog2(line_bits / 8);
    endfunction

    function automatic int idx_bits(input int mem_lines);
        return $clog2(mem_lines);
    endfunction

endpackage

// File: rtl/main_mem_array.sv
// rtl/main_mem_array.sv - single-port line store with synchronous write and registered read/echo port
module main_mem_array
    import main_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LINES  = 256,
    parameter int AW     = $clog2(LINES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [LINES];
    logic [DATA_W-1:0] rdata_d;
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // A write echoes its own data so the response path is one register for both kinds.
    always_comb begin
        rdata_d = rdata_q;
        if (we) begin
            rdata_d = wdata;
        end else if (re) begin
            rdata_d = mem[addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/main_memory_responder.sv
// rtl/main_memory_responder.sv - fixed-latency line memory responder; MAIN_MEM_STATS_EN adds read/write commit counters
module main_memory_responder
    import main_mem_pkg::*;
#(
    parameter int ADDRESS_WIDTH   = 32,
    parameter int CACHE_LINE_SIZE = 32,
    parameter int MEM_LINES       = 256,
    parameter int LATENCY         = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       reqValid_MEM,
    input  logic [ADDRESS_WIDTH-1:0]   reqAddress_MEM,
    input  logic [CACHE_LINE_SIZE-1:0] reqDataOut_MEM,
    input  logic                       reqWen_MEM,
    output logic                       respValid_MEM,
    output logic [CACHE_LINE_SIZE-1:0] respDataIn_MEM
`ifdef MAIN_MEM_STATS_EN
    ,
    output logic [31:0]                rdCount_MEM,
    output logic [31:0]                wrCount_MEM
`endif
);

    localparam int OFF = off_bits(CACHE_LINE_SIZE);
    localparam int IDX = idx_bits(MEM_LINES);
    localparam int CW  = $clog2(LATENCY + 1);

    mm_state_t                  state_d, state_q;
    logic [CW-1:0]              cnt_d, cnt_q;
    logic [IDX-1:0]             idx_d, idx_q;
    logic [CACHE_LINE_SIZE-1:0] data_d, data_q;
    logic                       wen_d, wen_q;
    logic                       resp_valid_d, resp_valid_q;
    logic                       commit;
    logic                       unused_addr_bits;

    // Offset and high address bits do not select a line; lines alias modulo MEM_LINES.
    assign unused_addr_bits = ^{reqAddress_MEM[ADDRESS_WIDTH-1:OFF+IDX], reqAddress_MEM[OFF-1:0]};

    assign commit = (state_q == BUSY) && (cnt_q == '0);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        data_d       = data_q;
        wen_d        = wen_q;
        resp_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (reqValid_MEM) begin
                    idx_d   = reqAddress_MEM[OFF+IDX-1:OFF];
                    data_d  = reqDataOut_MEM;
                    wen_d   = reqWen_MEM;
                    cnt_d   = CW'(LATENCY - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (commit) begin
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                state_d = DRAIN;
            end
            default: begin
                if (!reqValid_MEM) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            data_q       <= '0;
            wen_q        <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            data_q       <= data_d;
            wen_q        <= wen_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    main_mem_array #(
        .DATA_W (CACHE_LINE_SIZE),
        .LINES  (MEM_LINES),
        .AW     (IDX)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (commit && wen_q),
        .re    (commit && !wen_q),
        .addr  (idx_q),
        .wdata (data_q),
        .rdata (respDataIn_MEM)
    );

    assign respValid_MEM = resp_valid_q;

`ifdef MAIN_MEM_STATS_EN
    logic [31:0] rd_count_d, rd_count_q;
    logic [31:0] wr_count_d, wr_count_q;

    always_comb begin
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (commit && !wen_q && rd_count_q != 32'hFFFF_FFFF) begin
            rd_count_d = rd_count_q + 32'd1;
        end
        if (commit && wen_q && wr_count_q != 32'hFFFF_FFFF) begin
            wr_count_d = wr_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign rdCount_MEM = rd_count_q;
    assign wrCount_MEM = wr_count_q;
`endif

endmodule
